// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, ALU
// operation codes, opcode/func fields and the decoded instruction class.
package mc_control_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_SHIFT,
    C_ITYPE,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_JR,
    C_ILLEGAL
  } inst_class_t;

endpackage

// File: rtl/mc_decode.sv
// Purely combinational instruction decoder: classifies op/func and supplies
// the ALU operation, immediate extension mode and destination select.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  output inst_class_t cls,
  output logic [3:0]  aluc,
  output logic        sext,
  output logic        regrt,
  output logic        legal
);

  always_comb begin
    cls   = C_ILLEGAL;
    aluc  = ALU_ADD;
    sext  = 1'b0;
    regrt = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        unique case (func)
          FN_ADD:  begin cls = C_RTYPE; aluc = ALU_ADD; end
          FN_SUB:  begin cls = C_RTYPE; aluc = ALU_SUB; end
          FN_AND:  begin cls = C_RTYPE; aluc = ALU_AND; end
          FN_OR:   begin cls = C_RTYPE; aluc = ALU_OR;  end
          FN_XOR:  begin cls = C_RTYPE; aluc = ALU_XOR; end
          FN_SLL:  begin cls = C_SHIFT; aluc = ALU_SLL; end
          FN_SRL:  begin cls = C_SHIFT; aluc = ALU_SRL; end
          FN_SRA:  begin cls = C_SHIFT; aluc = ALU_SRA; end
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI: begin cls = C_ITYPE; aluc = ALU_ADD; sext = 1'b1; regrt = 1'b1; end
      OP_ANDI: begin cls = C_ITYPE; aluc = ALU_AND; regrt = 1'b1; end
      OP_ORI:  begin cls = C_ITYPE; aluc = ALU_OR;  regrt = 1'b1; end
      OP_XORI: begin cls = C_ITYPE; aluc = ALU_XOR; regrt = 1'b1; end
      OP_LUI:  begin cls = C_LUI;   aluc = ALU_LUI; regrt = 1'b1; end
      OP_LW:   begin cls = C_LW;  sext = 1'b1; regrt = 1'b1; end
      OP_SW:   begin cls = C_SW;  sext = 1'b1; end
      OP_BEQ:  begin cls = C_BEQ; aluc = ALU_SUB; sext = 1'b1; end
      OP_BNE:  begin cls = C_BNE; aluc = ALU_SUB; sext = 1'b1; end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
    legal = (cls != C_ILLEGAL);
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (IF/ID/EXE/MEM/WB). The state register is the
// only storage; all datapath controls are decoded from state and op/func.
module mc_control
  import mc_control_pkg::*;
#(
  parameter bit STALL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       sext,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] aluc,
  output logic [2:0] state,
  output logic       illegal
);

  state_t      state_q, state_d;
  inst_class_t cls;
  logic [3:0]  dec_aluc;
  logic        dec_sext, dec_regrt, dec_legal;
  logic        rdy;

  assign rdy   = STALL_EN ? mem_ready : 1'b1;
  assign state = state_q;

  mc_decode u_decode (
    .op    (op),
    .func  (func),
    .cls   (cls),
    .aluc  (dec_aluc),
    .sext  (dec_sext),
    .regrt (dec_regrt),
    .legal (dec_legal)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pcwrite = 1'b0;
    irwrite = 1'b0;
    wmem    = 1'b0;
    wreg    = 1'b0;
    iord    = 1'b0;
    regrt   = 1'b0;
    m2reg   = 1'b0;
    jal     = 1'b0;
    sext    = 1'b0;
    alusrca = 2'b00;
    alusrcb = 2'b00;
    pcsrc   = 2'b00;
    aluc    = ALU_ADD;
    illegal = 1'b0;

    unique case (state_q)
      S_IF: begin
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
        state_d = rdy ? S_ID : S_IF;
      end
      // ID always precomputes PC + (imm<<2) so a branch target is ready in EXE.
      S_ID: begin
        alusrcb = 2'b11;
        sext    = 1'b1;
        state_d = S_EXE;
        unique case (cls)
          C_J:   begin pcwrite = 1'b1; pcsrc = 2'b10; state_d = S_IF; end
          C_JAL: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
            wreg    = 1'b1;
            jal     = 1'b1;
            state_d = S_IF;
          end
          C_JR:  begin pcwrite = 1'b1; pcsrc = 2'b11; state_d = S_IF; end
          C_ILLEGAL: begin illegal = !dec_legal; state_d = S_IF; end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        state_d = S_IF;
        unique case (cls)
          C_RTYPE: begin
            alusrca = 2'b01; alusrcb = 2'b00; aluc = dec_aluc; state_d = S_WB;
          end
          C_SHIFT: begin
            alusrca = 2'b10; alusrcb = 2'b00; aluc = dec_aluc; state_d = S_WB;
          end
          C_ITYPE: begin
            alusrca = 2'b01; alusrcb = 2'b10; aluc = dec_aluc;
            sext = dec_sext; regrt = 1'b1; state_d = S_WB;
          end
          C_LUI: begin
            alusrcb = 2'b10; aluc = ALU_LUI; regrt = 1'b1; state_d = S_WB;
          end
          C_LW, C_SW: begin
            alusrca = 2'b01; alusrcb = 2'b10; aluc = ALU_ADD;
            sext = 1'b1; state_d = S_MEM;
          end
          C_BEQ, C_BNE: begin
            alusrca = 2'b01; alusrcb = 2'b00; aluc = ALU_SUB; pcsrc = 2'b01;
            pcwrite = (cls == C_BEQ) ? z : !z;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        unique case (cls)
          C_SW:    begin wmem = rdy; state_d = rdy ? S_IF : S_MEM; end
          C_LW:    state_d = rdy ? S_WB : S_MEM;
          default: state_d = S_IF;
        endcase
      end
      S_WB: begin
        wreg    = 1'b1;
        m2reg   = (cls == C_LW);
        regrt   = dec_regrt;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset is asynchronous, so write enables must drop with clrn itself,
    // not a clock later when the state register catches up.
    if (!clrn) begin
      pcwrite = 1'b0;
      irwrite = 1'b0;
      wmem    = 1'b0;
      wreg    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter STALL_EN, default 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 op  input  6  opcode field of the instruction register (IR[31:26]).
REQ-005 func  input  6  function field (IR[5:0]); used only when op=000000.
REQ-006 z  input  1  ALU zero flag from the current EXE-cycle computation.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 pcwrite, irwrite, wmem, wreg  output  1 each  PC, IR, memory and register-file write enables.
REQ-009 iord, regrt, m2reg, jal, sext  output  1 each  address = ALU register (1) or PC (0); dest = rt; writeback from MDR; link write to r31; sign-extend imm.
REQ-010 alusrca  output  2  ALU A select: 00 PC, 01 rs, 10 sa (zero-extended shamt).
REQ-011 alusrcb  output  2  ALU B select: 00 rt, 01 constant 4, 10 ext imm, 11 ext imm<<2.
REQ-012 pcsrc  output  2  PC source: 00 ALU result, 01 ALU-out register (branch target), 10 jump address, 11 rs.
REQ-013 aluc  output  4  ALU op: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
REQ-014 state  output  3  current state encoding; illegal  output  1  one-cycle pulse on undecodable instruction.

Function
REQ-015 States SHALL be IF, ID, EXE, MEM, WB, with encodings 000, 001, 010, 011 and 100 respectively; the state register is the only storage.
REQ-016 IF: iord=0, alusrca=00, alusrcb=01, aluc=ADD, pcsrc=00; irwrite=pcwrite=mem_ready; IF->ID when mem_ready=1, otherwise hold IF.
REQ-017 ID: alusrca=00, alusrcb=11, sext=1, aluc=ADD, so the branch target is latched into ALU-out.
REQ-018 ID with j (000010): pcwrite=1, pcsrc=10, then ->IF.
REQ-019 ID with jal (000011): pcwrite=1, pcsrc=10, wreg=1, jal=1, then ->IF.
REQ-020 ID with jr (op 0, func 001000): pcwrite=1, pcsrc=11, then ->IF.
REQ-021 ID with any other legal instruction ->EXE.
REQ-022 EXE R-type: add/sub/and/or/xor (func 100000/100010/100100/100101/100110) use alusrca=01, alusrcb=00, matching aluc, then ->WB.
REQ-023 EXE shifts: sll/srl/sra (func 000000/000010/000011) use alusrca=10, alusrcb=00, aluc SLL/SRL/SRA, then ->WB.
REQ-024 EXE I-type: addi (001000) uses sext=1; andi/ori/xori (001100/001101/001110) use sext=0; all use alusrca=01, alusrcb=10, then ->WB with regrt=1.
REQ-025 EXE lui (001111): aluc=LUI, alusrcb=10, then ->WB with regrt=1.
REQ-026 EXE lw/sw (100011/101011): aluc=ADD, alusrca=01, alusrcb=10, sext=1, then ->MEM.
REQ-027 EXE beq/bne (000100/000101): aluc=SUB, alusrca=01, alusrcb=00, pcsrc=01; pcwrite=z for beq and pcwrite=~z for bne, then ->IF.
REQ-028 MEM: iord=1; sw sets wmem=mem_ready and goes ->IF when ready; lw goes ->WB when ready; both hold MEM while mem_ready=0.
REQ-029 WB: wreg=1 for exactly one cycle, m2reg=1 only for lw, then ->IF.
REQ-030 Undecodable op/func in ID: illegal=1 for one cycle, no write enables asserted, then ->IF.
REQ-031 All write enables SHALL be 0 in any cycle not named above; outputs are Moore-decoded from state and op/func, except the mem_ready- and z-qualified enables.
REQ-032 mem_ready is ignored outside IF and MEM.

Reset
REQ-033 clrn=0 SHALL immediately force state=IF, illegal=0 and all write enables to 0, including in mid-MEM or mid-WB states.
REQ-034 First IF SHALL occur on the first rising clk after clrn deasserts.

Structure
REQ-035 A shared package SHALL hold state encodings, aluc constants, opcode and func constants.
REQ-036 Combinational sub-module mc_decode (op, func -> instruction class, aluc, sext, regrt, legal) SHALL be instantiated once; the FSM stays in mc_control.

Verification
REQ-037 add, op=000000, func=100000, mem_ready=1 -> states IF,ID,EXE,WB over 4 cycles; aluc=0000 in EXE; wreg=1 only in WB.
REQ-038 beq, op=000100: z=1 -> pcwrite=1 with pcsrc=01 in EXE; repeating with z=0 -> pcwrite=0; both return to IF next cycle.
REQ-039 lw, op=100011, mem_ready=0 for 2 MEM cycles -> MEM held 3 cycles; then WB with m2reg=1, wreg=1.
REQ-040 sra, func=000011 -> aluc=1111, alusrca=10 in EXE; jal, op=000011 -> wreg=1, jal=1, pcsrc=10 in ID, next state IF.
REQ-041 op=111111 -> illegal pulses one cycle in ID, no write enables asserted, next state IF.
REQ-042 clrn asserted mid-MEM on sw -> wmem drops to 0 asynchronously and state=000 before the next clk edge.
